// File: rtl/median_wr_pkg.sv
// Shared types for the median frame writer: FSM state encoding and checksum width.
package median_wr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int CHECKSUM_W = 32;

endpackage

// File: rtl/median_frame_writer_valid_delay.sv
// valid_delay: LATENCY-stage 1-bit shift register that realigns the window-valid
// flag with the filter's median output. Asynchronous active-high reset clears every stage.
module valid_delay #(
    parameter int LATENCY = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_valid,
    output logic o_valid
);

    logic r_stage [LATENCY];

    generate
        for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) r_stage[gi] <= 1'b0;
                    else     r_stage[gi] <= i_valid;
                end
            end else begin : g_next
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) r_stage[gi] <= 1'b0;
                    else     r_stage[gi] <= r_stage[gi-1];
                end
            end
        end
    endgenerate

    assign o_valid = r_stage[LATENCY-1];

endmodule

// File: rtl/median_frame_writer.sv
// median_frame_writer: tracks raster position of the filter input, drops border/warm-up
// medians and writes interior results to a cropped linear frame buffer.
// Optional running checksum of written data when MEDIAN_WR_CHECKSUM_EN is defined.
module median_frame_writer
    import median_wr_pkg::*;
#(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int PIXEL_BIT = 8,
    parameter int LATENCY   = 3,
    parameter int ADDR_W    = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [PIXEL_BIT-1:0] median_i,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [PIXEL_BIT-1:0] wr_data,
    output logic                 busy,
    output logic                 done
`ifdef MEDIAN_WR_CHECKSUM_EN
    ,
    output logic [CHECKSUM_W-1:0] checksum
`endif
);

    localparam int COL_W   = (IMG_W > 2) ? $clog2(IMG_W) : 2;
    localparam int ROW_W   = (IMG_H > 2) ? $clog2(IMG_H) : 2;
    localparam int CNT_W   = ADDR_W + 1;
    localparam int OUT_PIX = (IMG_W - 2) * (IMG_H - 2);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0] COL_ONE   = COL_W'(1);
    localparam logic [COL_W-1:0] COL_TWO   = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0] ROW_ONE   = ROW_W'(1);
    localparam logic [ROW_W-1:0] ROW_TWO   = ROW_W'(2);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FINAL = CNT_W'(OUT_PIX);

    state_t               r_state;
    state_t               w_state_next;
    logic [COL_W-1:0]     r_col_in;
    logic [ROW_W-1:0]     r_row_in;
    logic [CNT_W-1:0]     r_out_cnt;
    logic                 r_wr_en;
    logic [ADDR_W-1:0]    r_wr_addr;
    logic [PIXEL_BIT-1:0] r_wr_data;
    logic                 w_start_acc;
    logic                 w_win_valid;
    logic                 w_dly_valid;
    logic                 w_busy;
    logic                 w_done;

    assign w_start_acc = (r_state == IDLE) && start;
    assign w_win_valid = (r_state == RUN) && (r_row_in >= ROW_TWO) && (r_col_in >= COL_TWO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_next = RUN;
            end
            RUN: begin
                w_busy = 1'b1;
                if ((r_row_in == ROW_LAST) && (r_col_in == COL_LAST)) w_state_next = DRAIN;
            end
            DRAIN: begin
                w_busy = 1'b1;
                if (r_out_cnt == CNT_FINAL) w_state_next = DONE;
            end
            DONE: begin
                w_done       = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Pixel (0,0) is on the input in the accepting IDLE cycle, so RUN begins at (0,1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col_in <= '0;
            r_row_in <= '0;
        end else if (w_start_acc) begin
            r_col_in <= COL_ONE;
            r_row_in <= '0;
        end else if (r_state == RUN) begin
            if (r_col_in == COL_LAST) begin
                r_col_in <= '0;
                if (r_row_in != ROW_LAST) r_row_in <= r_row_in + ROW_ONE;
            end else begin
                r_col_in <= r_col_in + COL_ONE;
            end
        end
    end

    valid_delay #(
        .LATENCY (LATENCY)
    ) u_valid_delay (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_win_valid),
        .o_valid (w_dly_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_cnt <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else if (w_dly_valid) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_out_cnt[ADDR_W-1:0];
            r_wr_data <= median_i;
            r_out_cnt <= r_out_cnt + CNT_ONE;
        end else begin
            r_wr_en <= 1'b0;
            if (w_start_acc) r_out_cnt <= '0;
        end
    end

`ifdef MEDIAN_WR_CHECKSUM_EN
    logic [CHECKSUM_W-1:0] r_checksum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              r_checksum <= '0;
        else if (w_start_acc) r_checksum <= '0;
        else if (r_wr_en)     r_checksum <= r_checksum + CHECKSUM_W'(r_wr_data);
    end

    assign checksum = r_checksum;
`endif

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy    = w_busy;
    assign done    = w_done;

endmodule

// File: tb/tb_median_frame_writer.sv
// Scoreboard bench for median_frame_writer (IMG_W=5, IMG_H=4, LATENCY=3): random medians
// and start patterns, expected writes derived from raster arithmetic.
module tb_median_frame_writer;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int L  = 3;
    localparam int AW = 18;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    median_i = 8'd0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          busy;
    logic          done;
`ifdef MEDIAN_WR_CHECKSUM_EN
    logic [31:0]   checksum;
`endif

    median_frame_writer #(
        .IMG_W     (W),
        .IMG_H     (H),
        .PIXEL_BIT (8),
        .LATENCY   (L),
        .ADDR_W    (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .median_i (median_i),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done)
`ifdef MEDIAN_WR_CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int addr;
    } wr_t;

    wr_t        wq[$];
    int         dq[$];
    logic [7:0] med_hist [int];
    int         cyc = 0;
    int         idle_from = 0;
    int         busy_from = 1;
    int         busy_to = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    longint     exp_sum = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: a frame accepted in cycle c0 writes interior pixel (r,c), which enters
    // at cycle c0+r*W+c, one cycle after its median appears, to address (r-2)*(W-2)+(c-2).
    task automatic accept(input int c0);
        for (int r = 2; r < H; r++)
            for (int c = 2; c < W; c++)
                wq.push_back('{cyc: c0 + r*W + c + L + 1, addr: (r-2)*(W-2) + (c-2)});
        dq.push_back(c0 + W*H + L + 1);
        busy_from = c0 + 1;
        busy_to   = c0 + W*H + L;
        idle_from = c0 + W*H + L + 2;
        $display("frame start accepted at cycle %0d", c0);
    endtask

    task automatic step(input logic s, input logic [7:0] m);
        @(negedge clk);
        start = s;
        median_i = m;
        med_hist[cyc] = m;
        if (s && cyc >= idle_from) accept(cyc);
    endtask

    task automatic do_reset(input int hold);
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        wq.delete();
        dq.delete();
        busy_to = busy_from - 1;
        #1;
        check("rst_wr_en", {63'd0, wr_en}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_wr_addr", {46'd0, wr_addr}, 64'd0);
        repeat (hold) @(negedge clk);
        rst = 1'b0;
        med_hist[cyc] = median_i;
        idle_from = cyc;
        $display("reset released at cycle %0d", cyc);
    endtask

    // Monitor: compares the DUT against the scoreboard once per cycle, 1 time unit after the edge.
    always @(posedge clk) begin
        logic exp_we;
        logic exp_done;
        logic exp_busy;
        logic [7:0] exp_data;
        wr_t e;
        #1;
        if (rst) exp_sum = 0;
        while (wq.size() > 0 && wq[0].cyc < cyc) void'(wq.pop_front());
        while (dq.size() > 0 && dq[0] < cyc) void'(dq.pop_front());
        exp_we   = (wq.size() > 0) && (wq[0].cyc == cyc);
        exp_done = (dq.size() > 0) && (dq[0] == cyc);
        exp_busy = (cyc >= busy_from) && (cyc <= busy_to);
        check("wr_en", {63'd0, wr_en}, {63'd0, exp_we});
        check("busy", {63'd0, busy}, {63'd0, exp_busy});
        check("done", {63'd0, done}, {63'd0, exp_done});
        if (exp_we) begin
            e = wq.pop_front();
            exp_data = med_hist.exists(cyc - 1) ? med_hist[cyc - 1] : 8'd0;
            check("wr_addr", {46'd0, wr_addr}, 64'(e.addr));
            check("wr_data", {56'd0, wr_data}, {56'd0, exp_data});
            exp_sum = exp_sum + longint'(exp_data);
            $display("write cycle %0d addr %0d data %0d", cyc, wr_addr, wr_data);
        end
        if (exp_done) begin
            void'(dq.pop_front());
`ifdef MEDIAN_WR_CHECKSUM_EN
            check("checksum", {32'd0, checksum}, {32'd0, exp_sum[31:0]});
`endif
            exp_sum = 0;
            $display("done at cycle %0d", cyc);
        end
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle_from = cyc;

        // Single frame with random medians.
        step(1'b1, 8'($urandom));
        repeat (30) step(1'b0, 8'($urandom));

        // Median equals cycle number: addresses 0 and 5 carry 15 and 22 relative to start.
        begin
            int c0;
            c0 = cyc + 1;
            step(1'b1, 8'(c0 % 256));
            repeat (30) step(1'b0, 8'((cyc + 1) % 256));
        end

        // Start held high for 31 cycles: only the second start after DONE is accepted.
        repeat (31) step(1'b1, 8'($urandom));
        repeat (30) step(1'b0, 8'($urandom));

        // Reset in the middle of a frame, then a full frame afterwards.
        step(1'b1, 8'($urandom));
        repeat (17) step(1'b0, 8'($urandom));
        do_reset(2);
        repeat (3) step(1'b0, 8'($urandom));
        step(1'b1, 8'($urandom));
        repeat (30) step(1'b0, 8'($urandom));

        // Constant median: checksum 1200 at done.
        step(1'b1, 8'd200);
        repeat (30) step(1'b0, 8'd200);

        // Random starts and data.
        repeat (600) step($urandom_range(0, 7) == 0, 8'($urandom));
        repeat (40) step(1'b0, 8'($urandom));

        check("pending_expectations", 64'(wq.size() + dq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
